// File: rtl/bcd_pkg.sv
// Shared BCD digit constants and helpers for the N-digit up/down counter.
package bcd_pkg;
  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] BCD_MIN     = 4'd0;

  function automatic logic bcd_digit_valid(input logic [BCD_DIGIT_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

  function automatic logic [BCD_DIGIT_W-1:0] bcd_clamp(input logic [BCD_DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the increment/decrement ripple; moves only when ci is set.
module bcd_digit_step
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  input  logic                   up,
  input  logic                   ci,
  output logic [BCD_DIGIT_W-1:0] nxt,
  output logic                   co
);
  always_comb begin
    nxt = digit;
    if (ci) begin
      if (up) nxt = (digit >= BCD_MAX) ? BCD_MIN : digit + 4'd1;
      else    nxt = (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
    end
  end

  assign co = ci & (up ? (digit == BCD_MAX) : (digit == BCD_MIN));
endmodule

// File: rtl/bcd_updown_counter_n.sv
// N-digit BCD up/down counter with validated load, programmable limit and
// wrap/saturate boundary behaviour.
module bcd_updown_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                          clk,
  input  logic                          Clr,
  input  logic                          Enable,
  input  logic                          Load,
  input  logic                          Up,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] D,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] Limit,
  output logic [BCD_DIGIT_W*DIGITS-1:0] Q,
  output logic                          CO,
  output logic                          LoadErr
);
  localparam int W = BCD_DIGIT_W * DIGITS;

  logic [W-1:0]      eff_lim;
  logic [W-1:0]      step_q;
  logic [W-1:0]      cnt_q;
  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] d_dig_ok;
  logic              d_valid;
  logic              up_term;
  logic              dn_term;

  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign eff_lim[g*BCD_DIGIT_W +: BCD_DIGIT_W] = bcd_clamp(Limit[g*BCD_DIGIT_W +: BCD_DIGIT_W]);
    assign d_dig_ok[g] = bcd_digit_valid(D[g*BCD_DIGIT_W +: BCD_DIGIT_W]);

    bcd_digit_step u_step (
      .digit (Q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .up    (Up),
      .ci    (carry[g]),
      .nxt   (step_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .co    (carry[g+1])
    );
  end

  // With all digits valid BCD, binary magnitude compare matches decimal order.
  assign d_valid = (&d_dig_ok) && (D <= eff_lim);
  assign up_term = (Q >= eff_lim);
  // Borrow falling off the top digit in down mode means every digit was 0.
  assign dn_term = carry[DIGITS];

  always_comb begin
    cnt_q = step_q;
    if (Up) begin
      if (up_term) cnt_q = WRAP ? '0 : Q;
    end else begin
      if (dn_term) cnt_q = WRAP ? eff_lim : Q;
    end
  end

  assign CO = Enable & ~Load & (Up ? up_term : dn_term);

  always_ff @(posedge clk or posedge Clr) begin
    if (Clr) begin
      Q       <= '0;
      LoadErr <= 1'b0;
    end else if (Load) begin
      if (d_valid) begin
        Q       <= D;
        LoadErr <= 1'b0;
      end else begin
        LoadErr <= 1'b1;
      end
    end else if (Enable) begin
      Q <= cnt_q;
    end
  end
endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Bench for bcd_updown_counter_n: wrap and saturate instances against a decimal reference model.
module tb_bcd_updown_counter_n;
  logic        clk = 1'b0;
  logic        Clr, Enable, Load, Up;
  logic [15:0] D, Limit;
  logic [15:0] q_w, q_s;
  logic        co_w, co_s, err_w, err_s;

  int n_tests = 0;
  int n_fail  = 0;
  int mq[2];   // model count as integer, [0]=wrap, [1]=saturate
  bit me[2];

  always #5 clk = ~clk;

  bcd_updown_counter_n #(.DIGITS(4), .WRAP(1'b1)) u_w (
    .clk(clk), .Clr(Clr), .Enable(Enable), .Load(Load), .Up(Up),
    .D(D), .Limit(Limit), .Q(q_w), .CO(co_w), .LoadErr(err_w));

  bcd_updown_counter_n #(.DIGITS(4), .WRAP(1'b0)) u_s (
    .clk(clk), .Clr(Clr), .Enable(Enable), .Load(Load), .Up(Up),
    .D(D), .Limit(Limit), .Q(q_s), .CO(co_s), .LoadErr(err_s));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int eff_of(input logic [15:0] l);
    int v = 0;
    for (int i = 3; i >= 0; i--) v = v * 10 + ((l[i*4 +: 4] > 4'd9) ? 9 : int'(l[i*4 +: 4]));
    return v;
  endfunction

  function automatic logic [15:0] i2b(input int v);
    logic [15:0] b;
    int t = v;
    for (int i = 0; i < 4; i++) begin
      b[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  function automatic bit d_ok(input logic [15:0] d, input logic [15:0] l);
    for (int i = 0; i < 4; i++) if (d[i*4 +: 4] > 4'd9) return 1'b0;
    return eff_of(d) <= eff_of(l);
  endfunction

  // One clock: check CO mid-cycle, advance the model, check registers after the edge.
  task automatic cyc();
    int eff, nq[2];
    bit ne[2], eco;
    @(negedge clk);
    eff = eff_of(Limit);
    for (int k = 0; k < 2; k++) begin
      eco = Enable && !Load && ((Up && mq[k] >= eff) || (!Up && mq[k] == 0));
      chk(k == 0 ? "co_wrap" : "co_sat", k == 0 ? co_w : co_s, eco);
      nq[k] = mq[k];
      ne[k] = me[k];
      if (Load) begin
        if (d_ok(D, Limit)) begin nq[k] = eff_of(D); ne[k] = 1'b0; end
        else ne[k] = 1'b1;
      end else if (Enable) begin
        if (Up) nq[k] = (mq[k] < eff) ? mq[k] + 1 : (k == 0 ? 0 : mq[k]);
        else    nq[k] = (mq[k] != 0) ? mq[k] - 1 : (k == 0 ? eff : mq[k]);
      end
    end
    @(posedge clk);
    mq = nq;
    me = ne;
    #1;
    chk("q_wrap",   q_w,   i2b(mq[0]));
    chk("q_sat",    q_s,   i2b(mq[1]));
    chk("err_wrap", err_w, me[0]);
    chk("err_sat",  err_s, me[1]);
  endtask

  task automatic ld(input logic [15:0] d);
    Load = 1'b1; Enable = 1'b0; D = d;
    cyc();
    Load = 1'b0;
  endtask

  initial begin
    Clr = 1'b1; Enable = 1'b0; Load = 1'b0; Up = 1'b1; D = '0; Limit = 16'h9999;
    mq[0] = 0; mq[1] = 0; me[0] = 0; me[1] = 0;
    #12;
    chk("rst_q",   q_w,   16'h0000);
    chk("rst_err", err_s, 1'b0);
    Clr = 1'b0;
    @(posedge clk); #1;

    // Up carry chain and wrap/saturate at the limit
    ld(16'h0999); Enable = 1'b1; Up = 1'b1; cyc();
    chk("carry_1000", q_w, 16'h1000);
    ld(16'h9999); Enable = 1'b1; Up = 1'b1; cyc();
    chk("wrap_to_0", q_w, 16'h0000);
    chk("sat_9999",  q_s, 16'h9999);

    // Down borrow and wrap to the limit
    Limit = 16'h0250;
    ld(16'h0100); Enable = 1'b1; Up = 1'b0; cyc();
    chk("borrow_99", q_w, 16'h0099);
    ld(16'h0000); Enable = 1'b1; Up = 1'b0; cyc();
    chk("wrap_to_lim", q_w, 16'h0250);
    chk("sat_zero",    q_s, 16'h0000);

    // Saturation with CO held high
    Limit = 16'h0059;
    ld(16'h0058); Enable = 1'b1; Up = 1'b1;
    repeat (3) cyc();
    chk("sat_59", q_s, 16'h0059);

    // Load validation
    Limit = 16'h0500;
    ld(16'h12A4); chk("bad_digit", err_w, 1'b1);
    ld(16'h0600); chk("over_lim",  err_s, 1'b1);
    ld(16'h0300); chk("good_load", q_w, 16'h0300);
    Load = 1'b1; Enable = 1'b1; Up = 1'b1; D = 16'h0400; cyc(); Load = 1'b0;
    chk("load_prio", q_w, 16'h0400);

    // Limit lowered below Q
    Limit = 16'h9999; ld(16'h0800);
    Limit = 16'h0500; Enable = 1'b1; Up = 1'b1; cyc();
    chk("lim_drop_up", q_w, 16'h0000);
    Limit = 16'h9999; ld(16'h0800);
    Limit = 16'h0500; Enable = 1'b1; Up = 1'b0; cyc();
    chk("lim_drop_dn", q_w, 16'h0799);

    // Limit = 0 and clamped limit digits
    Limit = 16'h0000; ld(16'h0000);
    Enable = 1'b1; Up = 1'b1; cyc();
    Up = 1'b0; cyc();
    chk("lim0", q_w, 16'h0000);
    Limit = 16'h00AF; ld(16'h0099); Enable = 1'b1; Up = 1'b1; cyc();
    chk("clamp_lim", q_w, 16'h0000);

    // Asynchronous clear between edges
    Limit = 16'h9999; ld(16'h0427); ld(16'h12A4);
    #2 Clr = 1'b1;
    #1;
    chk("aclr_q",   q_w,   16'h0000);
    chk("aclr_err", err_w, 1'b0);
    chk("aclr_qs",  q_s,   16'h0000);
    Clr = 1'b0;
    mq[0] = 0; mq[1] = 0; me[0] = 0; me[1] = 0;

    // Randomized run, limits biased small so boundaries are hit often
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 40) == 0) begin
        if ($urandom_range(0, 3) == 0)
          for (int i = 0; i < 4; i++) Limit[i*4 +: 4] = 4'($urandom_range(0, 15));
        else
          Limit = i2b($urandom_range(0, 150));
      end
      Load   = ($urandom_range(0, 7) == 0);
      Enable = ($urandom_range(0, 3) != 0);
      Up     = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 3) == 0) D = 16'($urandom);
      else D = i2b($urandom_range(0, eff_of(Limit) + 5));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_updown_counter_n.md
Name: bcd_updown_counter_n

Overview:
- Parametrised N-digit BCD up/down counter with synchronous load.
- Programmable upper limit (BCD); selectable wrap or saturate mode at the count boundaries.
- Flags invalid load data.
- Successor to the fixed four-digit BCD counter; used for timers, event tallies and display-driven counts where digit count and modulus vary per instance.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); data width is 4*DIGITS.
- WRAP, 1, 1 = wrap at the boundaries; 0 = saturate (hold) at the boundaries.

Ports:
- clk  in  1  system clock, rising edge.
- Clr  in  1  asynchronous active-high reset.
- Enable  in  1  count enable for this cycle.
- Load  in  1  synchronous load of D; takes priority over Enable.
- Up  in  1  1 = count up, 0 = count down.
- D  in  4*DIGITS  BCD load value; digit 0 in [3:0].
- Limit  in  4*DIGITS  BCD upper bound (inclusive); quasi-static.
- Q  out  4*DIGITS  registered BCD count.
- CO  out  1  combinational terminal-count strobe.
- LoadErr  out  1  registered; set by a rejected load.

Behaviour:
- Clock and reset: one clock, clk. Clr is asynchronous, active-high. While Clr=1: Q=0, LoadErr=0, regardless of clk.
- Effective limit: EffLim = Limit with any digit >9 clamped to 9, per digit. On valid BCD, magnitude compare equals plain binary compare of the vectors.
- Per-edge priority (when Clr=0): Load, then Enable, then hold.
- Load=1:
  - D is valid when every digit is ≤9 and D ≤ EffLim.
  - Valid D: Q<=D, LoadErr<=0.
  - Invalid D: Q unchanged, LoadErr<=1.
  - Enable and Up are ignored in a Load cycle.
- Enable=1, Load=0, Up=1:
  - Q<EffLim: Q<=Q+1 in BCD. Digit i increments only when digits 0..i-1 are all 9; a digit at 9 becomes 0.
  - Q≥EffLim (terminal): WRAP=1 gives Q<=0; WRAP=0 holds Q.
- Enable=1, Load=0, Up=0:
  - Q≠0: Q<=Q-1 in BCD. Digit i decrements only when digits 0..i-1 are all 0; a digit at 0 becomes 9.
  - Q=0 (terminal): WRAP=1 gives Q<=EffLim; WRAP=0 holds Q.
- Enable=0, Load=0: Q holds.
- LoadErr changes only on Load cycles or Clr; it is sticky across counting.
- Latency: Q updates one edge after the qualifying inputs. CO is valid in the same cycle as its inputs, i.e. the cycle before the wrap or saturate edge.
- CO = Enable & ~Load & ((Up & Q≥EffLim) | (~Up & Q==0)). Asserted in both WRAP modes. CO stays high each enabled cycle while saturated.
- Limit lowered below the current Q:
  - Up: the next enabled edge is terminal (wrap to 0, or hold).
  - Down: counts down normally.
- Limit=0: up and down both terminal at Q=0. WRAP=1 keeps Q=0.
- DIGITS=1: single-digit behaviour, no inter-digit carry logic.
- No X propagation from D while Load=0.

Decomposition:
- Package bcd_pkg:
  - BCD_DIGIT_W=4, BCD_MAX=4'd9, BCD_MIN=4'd0.
  - Function bcd_digit_valid(d).
  - Function bcd_clamp(d), returning min(d,9).
- Sub-module bcd_digit_step, combinational, one per digit via generate:
  - Inputs: digit, up, ci (carry/borrow in).
  - Outputs: next digit, co (=up?digit==9&ci:digit==0&ci).
- Top level holds:
  - the Q register and LoadErr;
  - the validity and limit compares;
  - the priority and boundary mux;
  - CO.

Test Plan (DIGITS=4 unless noted):
- Reset mid-count: Q=0x0427, pulse Clr asynchronously between edges -> Q=0x0000 and LoadErr=0 immediately, before the next edge.
- Up carry chain, WRAP=1, Limit=0x9999: Load 0x0999, Enable=1, Up=1 -> Q=0x1000 after one edge. Load 0x9999 -> CO=1 that cycle, then Q=0x0000.
- Down borrow and wrap to limit, WRAP=1, Limit=0x0250: Load 0x0100, Up=0 -> Q=0x0099. Load 0x0000 -> CO=1, then Q=0x0250.
- Saturate, WRAP=0, Limit=0x0059: Load 0x0058, Up=1, three enabled edges -> Q=0x0059, 0x0059, 0x0059. CO=1 on the 2nd and 3rd cycles.
- Load validation: D=0x12A4 -> Q unchanged, LoadErr=1. With Limit=0x0500, D=0x0600 -> LoadErr=1. D=0x0300 -> Q=0x0300, LoadErr=0. Load=1 with Enable=1 in the same cycle -> Q=D, no count.
- Limit change, WRAP=1: Q=0x0800, Limit set to 0x0500, Up=1, Enable -> CO=1, next Q=0x0000. Same setup with Up=0 -> Q=0x0799, CO=0.
